// File: rtl/uc_arbiter_wrap.sv
// ---------------------------------------------------------------------------
// uc_arbiter_wrap -- unit-clause arbiter between clause memory and the BCP
// engines.
//
// It queues the initial unit literals that arrive from memory and broadcasts
// them one by one to every engine (state LOAD). After memory reports done and
// the queue has drained, it repeatedly picks the implied literal with the
// smallest variable index among the engine queue heads and broadcasts it
// (state ENG). A per-variable assignment table tracks every broadcast
// literal. A contradictory assignment raises a sticky conflict flag, which
// freezes the arbiter until reset.
//
// Handshake semantics: mem2uca is taken in any cycle where mem2uca_valid=1
// and the literal is legal. There is no back-pressure to memory; a push into
// a full queue is an overflow error and raises conflict. An engine head is a
// candidate when eng2uca_valid=1 and eng2uca_empty=0. A broadcast is a single
// cycle with uca2eng_pop=1: every engine enqueues uca2eng, and an engine
// whose head equals uca2eng retires that head. Any bit of uca2eng_full
// blocks the start of a new broadcast.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem2uca_valid   memory literal valid this cycle
//   mem2uca_done    memory finished sending (level)
//   mem2uca         memory unit literal (signed, +/-var, 0 = none)
//   eng2uca_min     packed engine head literals, engine i at [i*LW +: LW]
//   eng2uca_valid   per-engine head valid
//   eng2uca_empty   per-engine implication queue empty
//   uca2eng_full    per-engine input queue full (stalls broadcast)
//   uca2eng         broadcast literal (holds its value between strobes)
//   uca2eng_pop     broadcast strobe, one cycle
//   conflict        sticky conflict flag
//   dbg_state       current state (0 = LOAD, 1 = ENG)
//
// Optional build macro: UCA_DEDUP_EN. When it is defined, a memory literal
// that is already assigned with the same sign is dropped from the queue
// without a strobe. Engine-path repeats still strobe, because the engines
// need the strobe to retire their matching heads.
// ---------------------------------------------------------------------------
module uc_arbiter_wrap #(
    parameter int  NUM_ENGINE  = 4,
    parameter int  LIT_IDX_MAX = 64,
    parameter int  MEM_Q_DEPTH = 16,
    localparam int LW          = $clog2(LIT_IDX_MAX) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mem2uca_valid,
    input  logic                           mem2uca_done,
    input  logic signed [LW-1:0]           mem2uca,
    input  logic signed [NUM_ENGINE*LW-1:0] eng2uca_min,
    input  logic [NUM_ENGINE-1:0]          eng2uca_valid,
    input  logic [NUM_ENGINE-1:0]          eng2uca_empty,
    input  logic [NUM_ENGINE-1:0]          uca2eng_full,
    output logic signed [LW-1:0]           uca2eng,
    output logic                           uca2eng_pop,
    output logic                           conflict,
    output logic                           dbg_state
);

    localparam int            AW      = $clog2(MEM_Q_DEPTH);
    localparam logic [LW-1:0] MAG_MAX = LW'(LIT_IDX_MAX);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(MEM_Q_DEPTH);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_ENG  = 1'b1
    } state_t;

    // Magnitude of a signed literal as an unsigned value. The most negative
    // code maps to LIT_IDX_MAX, so every variable index fits in LW bits.
    function automatic logic [LW-1:0] mag_of(input logic signed [LW-1:0] lit);
        logic [LW-1:0] u;
        u = lit;
        return lit[LW-1] ? (~u + LW'(1)) : u;
    endfunction

    // Registered state
    state_t                state_q, state_d;
    logic signed [LW-1:0]  bcast_lit_q;
    logic                  bcast_pop_q;
    logic                  conflict_q, conflict_d;
    logic [LIT_IDX_MAX:0]  assigned_q;   // bit 0 is unused
    logic [LIT_IDX_MAX:0]  neg_q;        // 1 = variable assigned negative
    logic signed [LW-1:0]  fifo_mem [MEM_Q_DEPTH];
    logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [AW:0]           fifo_cnt_q, fifo_cnt_d;

    // Engine candidate decode
    logic signed [LW-1:0]  head_lit [NUM_ENGINE];
    logic [LW-1:0]         head_mag [NUM_ENGINE];
    logic [NUM_ENGINE-1:0] cand;

    always_comb begin
        for (int i = 0; i < NUM_ENGINE; i++) begin
            head_lit[i] = eng2uca_min[i*LW +: LW];
            head_mag[i] = mag_of(head_lit[i]);
            cand[i]     = eng2uca_valid[i] && !eng2uca_empty[i] &&
                          (head_mag[i] != '0) && (head_mag[i] <= MAG_MAX);
        end
    end

    // Minimum-variable selection. The strict '<' keeps the lowest engine
    // index on ties. A second pass looks for the opposite polarity of the
    // chosen variable among the candidates.
    logic                 sel_found;
    logic signed [LW-1:0] sel_lit;
    logic [LW-1:0]        sel_mag;
    logic                 pair_clash;

    always_comb begin
        sel_found  = 1'b0;
        sel_lit    = '0;
        sel_mag    = '0;
        pair_clash = 1'b0;
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (cand[i] && (!sel_found || (head_mag[i] < sel_mag))) begin
                sel_found = 1'b1;
                sel_lit   = head_lit[i];
                sel_mag   = head_mag[i];
            end
        end
        for (int i = 0; i < NUM_ENGINE; i++) begin
            if (sel_found && cand[i] && (head_mag[i] == sel_mag) &&
                (head_lit[i][LW-1] != sel_lit[LW-1])) begin
                pair_clash = 1'b1;
            end
        end
    end

    // Broadcast decision for this cycle
    logic                 fifo_empty, fifo_full;
    logic [LW-1:0]        mem_mag;
    logic                 push_req, push_ok, overflow;
    logic                 in_load;
    logic signed [LW-1:0] cur_lit;
    logic [LW-1:0]        cur_mag;
    logic                 go, tab_hit, tab_clash, raise, bcast, pop_fifo, tab_wr;

    always_comb begin
        fifo_empty = (fifo_cnt_q == '0);
        fifo_full  = (fifo_cnt_q == DEPTH_C);
        mem_mag    = mag_of(mem2uca);
        push_req   = mem2uca_valid && (mem_mag != '0) && (mem_mag <= MAG_MAX) && !conflict_q;
        push_ok    = push_req && !fifo_full;
        overflow   = push_req && fifo_full;

        in_load = (state_q == ST_LOAD);
        cur_lit = in_load ? fifo_mem[rd_ptr_q] : sel_lit;
        cur_mag = mag_of(cur_lit);

        // The engine path skips the cycle right after a strobe so that the
        // engines can retire the head that was just broadcast.
        go = !conflict_q && (uca2eng_full == '0) &&
             (in_load ? !fifo_empty : (sel_found && !bcast_pop_q));

        tab_hit   = assigned_q[cur_mag];
        tab_clash = tab_hit && (neg_q[cur_mag] != cur_lit[LW-1]);
        raise     = go && (tab_clash || (!in_load && pair_clash));
        bcast     = go && !raise;
`ifdef UCA_DEDUP_EN
        if (in_load && tab_hit) begin
            bcast = 1'b0;
        end
`endif
        pop_fifo = go && in_load;
        tab_wr   = go && !raise;

        conflict_d = conflict_q || raise || overflow;

        state_d = state_q;
        if (in_load && mem2uca_done && fifo_empty && !push_req && !conflict_q) begin
            state_d = ST_ENG;
        end

        fifo_cnt_d = fifo_cnt_q;
        case ({push_ok, pop_fifo})
            2'b10:   fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FSM, registered outputs, assignment table and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            bcast_lit_q <= '0;
            bcast_pop_q <= 1'b0;
            conflict_q  <= 1'b0;
            assigned_q  <= '0;
            neg_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            conflict_q  <= conflict_d;
            bcast_pop_q <= bcast;
            if (bcast) begin
                bcast_lit_q <= cur_lit;
            end
            if (tab_wr) begin
                assigned_q[cur_mag] <= 1'b1;
                neg_q[cur_mag]      <= cur_lit[LW-1];
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_fifo) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage needs no reset, because the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= mem2uca;
        end
    end

    assign uca2eng     = bcast_lit_q;
    assign uca2eng_pop = bcast_pop_q;
    assign conflict    = conflict_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uc_arbiter_wrap.sv
// Testbench for uc_arbiter_wrap: directed scenarios plus randomized episodes.
// A transaction-level reference model checks the DUT every cycle. The model
// keeps a queue for the memory FIFO, a table of signs and per-engine literal
// queues.
module tb_uc_arbiter_wrap;
  localparam int NE    = 4;
  localparam int LMAX  = 64;
  localparam int DEPTH = 16;
  localparam int LW    = 7;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                   mem2uca_valid, mem2uca_done;
  logic signed [LW-1:0]   mem2uca;
  logic signed [NE*LW-1:0] eng2uca_min;
  logic [NE-1:0]          eng2uca_valid, eng2uca_empty, uca2eng_full;
  logic signed [LW-1:0]   uca2eng;
  logic                   uca2eng_pop, conflict, dbg_state;

  uc_arbiter_wrap dut (
    .clk(clk), .rst(rst),
    .mem2uca_valid(mem2uca_valid), .mem2uca_done(mem2uca_done), .mem2uca(mem2uca),
    .eng2uca_min(eng2uca_min), .eng2uca_valid(eng2uca_valid), .eng2uca_empty(eng2uca_empty),
    .uca2eng_full(uca2eng_full), .uca2eng(uca2eng), .uca2eng_pop(uca2eng_pop),
    .conflict(conflict), .dbg_state(dbg_state)
  );

  // stimulus state
  int      in_mlit;
  bit      in_mvalid, in_done;
  bit [NE-1:0] in_full, in_vmask;
  int      in_junk[NE];
  int      eng_q[NE][$];
  int      truth[13];

  // reference model state
  int      m_fifo[$];
  int      m_tab[LMAX+1];   // 0 unassigned, +1 positive, -1 negative
  bit      m_conf, m_pop, m_eng, m_new_conf;
  int      m_out;

  // scoreboard
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] seen_q[$];
  int n_cmp, n_err;

  task automatic check_val(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit is_cand(int i);
    if (!in_vmask[i] || eng_q[i].size() == 0) return 1'b0;
    if (eng_q[i][0] == 0) return 1'b0;
    return iabs(eng_q[i][0]) <= LMAX;
  endfunction

  // driver tasks
  task automatic idle();
    in_mvalid = 1'b0; in_mlit = 0; in_done = 1'b0;
    in_full = '0; in_vmask = '1;
    for (int i = 0; i < NE; i++) in_junk[i] = 0;
  endtask

  task automatic drive();
    mem2uca_valid = in_mvalid;
    mem2uca       = LW'(in_mlit);
    mem2uca_done  = in_done;
    uca2eng_full  = in_full;
    for (int i = 0; i < NE; i++) begin
      eng2uca_valid[i] = in_vmask[i];
      if (eng_q[i].size() > 0) begin
        eng2uca_min[i*LW +: LW] = LW'(eng_q[i][0]);
        eng2uca_empty[i] = 1'b0;
      end else begin
        eng2uca_min[i*LW +: LW] = LW'(in_junk[i]);
        eng2uca_empty[i] = 1'b1;
      end
    end
  endtask

  // reference model
  task automatic model_reset();
    m_fifo.delete();
    for (int v = 0; v <= LMAX; v++) m_tab[v] = 0;
    m_conf = 1'b0; m_pop = 1'b0; m_eng = 1'b0; m_out = 0;
  endtask

  task automatic decide(int lit, bit from_mem);
    int v, s;
    v = iabs(lit);
    s = (lit < 0) ? -1 : 1;
    if (m_tab[v] == -s) begin
      m_new_conf = 1'b1;
    end else if (m_tab[v] == s) begin
`ifdef UCA_DEDUP_EN
      if (!from_mem) begin m_pop = 1'b1; m_out = lit; end
`else
      m_pop = 1'b1; m_out = lit;
`endif
    end else begin
      m_tab[v] = s;
      m_pop = 1'b1; m_out = lit;
    end
  endtask

  task automatic model_step();
    bit push, old_pop;
    int pre, lit, best;
    old_pop = m_pop;
    m_pop = 1'b0;
    if (m_conf) return;
    m_new_conf = 1'b0;
    push = in_mvalid && (in_mlit != 0) && (iabs(in_mlit) <= LMAX);
    pre = m_fifo.size();
    if (in_full == '0) begin
      if (!m_eng && pre > 0) begin
        lit = m_fifo.pop_front();
        decide(lit, 1'b1);
      end else if (m_eng && !old_pop) begin
        best = -1;
        for (int i = 0; i < NE; i++) begin
          if (is_cand(i)) begin
            if (best < 0) best = i;
            else if (iabs(eng_q[i][0]) < iabs(eng_q[best][0])) best = i;
          end
        end
        if (best >= 0) begin
          lit = eng_q[best][0];
          for (int i = 0; i < NE; i++)
            if (is_cand(i) && eng_q[i][0] == -lit) m_new_conf = 1'b1;
          if (!m_new_conf) decide(lit, 1'b0);
        end
      end
    end
    if (push) begin
      if (pre == DEPTH) m_new_conf = 1'b1;
      else m_fifo.push_back(in_mlit);
    end
    if (!m_eng && in_done && pre == 0 && !push) m_eng = 1'b1;
    if (m_new_conf) m_conf = 1'b1;
  endtask

  // one clock: drive, advance model, sample after the edge, compare
  task automatic cycle();
    drive();
    model_step();
    @(posedge clk);
    #1;
    check_val("pop", int'(uca2eng_pop), int'(m_pop));
    check_val("lit", int'($signed(uca2eng)), m_out);
    check_val("conflict", int'(conflict), int'(m_conf));
    check_val("state", int'(dbg_state), int'(m_eng));
    if (uca2eng_pop) seen_q.push_back(uca2eng);
    // engines retire a head equal to the broadcast literal
    if (m_pop)
      for (int i = 0; i < NE; i++)
        if (eng_q[i].size() > 0 && eng_q[i][0] == m_out) void'(eng_q[i].pop_front());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    for (int i = 0; i < NE; i++) eng_q[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    seen_q.delete(); exp_q.delete();
    check_val("rst_pop", int'(uca2eng_pop), 0);
    check_val("rst_lit", int'($signed(uca2eng)), 0);
    check_val("rst_conflict", int'(conflict), 0);
    check_val("rst_state", int'(dbg_state), 0);
  endtask

  task automatic check_seen(string tag);
    check_val({tag, "_count"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      check_val(tag, int'($signed(seen_q[i])), int'($signed(exp_q[i])));
    seen_q.delete(); exp_q.delete();
  endtask

  task automatic push_exp(int lit);
    exp_q.push_back(LW'(lit));
  endtask

  function automatic int gen_lit();
    int v, s;
    v = $urandom_range(1, 12);
    s = truth[v];
    if ($urandom_range(0, 19) == 0) s = -s;
    return v * s;
  endfunction

  initial begin
    int t1[5];
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    idle();
    drive();

    // memory literals broadcast in order, then state ENG
    do_reset();
    t1 = '{10, 20, 30, 40, 50};
    for (int k = 0; k < 5; k++) begin
      in_mvalid = 1'b1; in_mlit = t1[k]; cycle();
      push_exp(t1[k]);
    end
    in_mvalid = 1'b0; in_done = 1'b1;
    repeat (8) cycle();
    check_seen("t1_bcast");
    check_val("t1_state", int'(dbg_state), 1);
    check_val("t1_conflict", int'(conflict), 0);

    // engine heads -1,3,-3,5: -1 broadcast, then 3/-3 pair conflicts
    do_reset();
    in_done = 1'b1;
    eng_q[0].push_back(-1); eng_q[1].push_back(3);
    eng_q[2].push_back(-3); eng_q[3].push_back(5);
    repeat (8) cycle();
    push_exp(-1);
    check_seen("t2_bcast");
    check_val("t2_conflict", int'(conflict), 1);

    // heads 4,2,7,2: broadcast 2 once, then 4, then 7
    do_reset();
    in_done = 1'b1;
    eng_q[0].push_back(4); eng_q[1].push_back(2);
    eng_q[2].push_back(7); eng_q[3].push_back(2);
    repeat (10) cycle();
    push_exp(2); push_exp(4); push_exp(7);
    check_seen("t3_bcast");
    check_val("t3_conflict", int'(conflict), 0);

    // memory 5 then -5: 5 broadcast, then conflict
    do_reset();
    in_mvalid = 1'b1; in_mlit = 5;  cycle();
    in_mlit = -5; cycle();
    in_mvalid = 1'b0; in_done = 1'b1;
    repeat (5) cycle();
    push_exp(5);
    check_seen("t4_bcast");
    check_val("t4_conflict", int'(conflict), 1);

    // reset after conflict; reset during an in-flight broadcast; then 7
    do_reset();
    in_mvalid = 1'b1; in_mlit = 9; cycle();
    do_reset();
    in_mvalid = 1'b1; in_mlit = 7; cycle();
    in_mvalid = 1'b0; in_done = 1'b1;
    repeat (4) cycle();
    push_exp(7);
    check_seen("t6_bcast");

    // full stall on engine 2
    do_reset();
    in_full = 4'b0100;
    in_mvalid = 1'b1; in_mlit = 10; cycle();
    in_mvalid = 1'b0;
    repeat (3) cycle();
    check_val("t5_stalled", seen_q.size(), 0);
    in_full = '0;
    cycle();
    check_val("t5_pop", int'(uca2eng_pop), 1);
    check_val("t5_lit", int'($signed(uca2eng)), 10);
    push_exp(10);
    check_seen("t5_bcast");

    // FIFO overflow raises conflict
    do_reset();
    in_full = '1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      in_mvalid = 1'b1; in_mlit = k; cycle();
    end
    in_mvalid = 1'b0; in_full = '0;
    check_val("t7_conflict", int'(conflict), 1);
    repeat (3) cycle();
    check_seen("t7_bcast");

    // randomized episodes
    for (int ep = 0; ep < 20; ep++) begin
      int nmem, pushed;
      do_reset();
      for (int v = 1; v <= 12; v++) truth[v] = ($urandom_range(0, 1) == 1) ? 1 : -1;
      nmem = $urandom_range(0, 20);
      pushed = 0;
      while (pushed < nmem) begin
        in_mvalid = ($urandom_range(0, 3) != 0);
        in_mlit = ($urandom_range(0, 9) == 0) ? 0 : gen_lit();
        in_full = ($urandom_range(0, 5) == 0) ? NE'($urandom_range(1, 15)) : '0;
        if (in_mvalid) pushed++;
        cycle();
      end
      in_mvalid = 1'b0; in_done = 1'b1;
      for (int i = 0; i < NE; i++) begin
        int n;
        n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++)
          eng_q[i].push_back(($urandom_range(0, 24) == 0) ? 0 : gen_lit());
      end
      repeat (70) begin
        for (int i = 0; i < NE; i++) begin
          in_vmask[i] = ($urandom_range(0, 7) != 0);
          in_junk[i] = gen_lit();
        end
        in_full = ($urandom_range(0, 5) == 0) ? NE'($urandom_range(1, 15)) : '0;
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
